// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel pixel packer.
package sobel_pkg;

   localparam int PIX_W        = 16;
   localparam int PIX_PER_WORD = 8;
   localparam int WORD_W       = PIX_W * PIX_PER_WORD;
   localparam int ACC_W        = WORD_W - PIX_W;
   localparam int PACK_CW      = $clog2(PIX_PER_WORD);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

   // Pointer width for a FIFO of the given depth; never narrower than one bit.
   function automatic int fifo_aw(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pix_word_fifo.sv
// Word FIFO with first-word-fall-through head; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module pix_word_fifo
   import sobel_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = WORD_W + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   output logic [DW-1:0] head_data_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int AW = fifo_aw(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic [AW:0]   count_d;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
      end
   end

   // Stale entries stay hidden so the head reads as zero whenever empty.
   assign head_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/sobel_pix_packer.sv
// Packs eight RGB565 edge pixels per 128-bit word, tracks frame position and
// queues words for the frame-buffer writer.
module sobel_pix_packer
   import sobel_pkg::*;
#(
   parameter int H_ACTIVE   = 1280,
   parameter int V_ACTIVE   = 720,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              sclk,
   input  logic              rst_n,
   input  logic              i_vs,
   input  logic [PIX_W-1:0]  pi_data,
   input  logic              pi_flag,
   output logic [WORD_W-1:0] o_wr_data,
   output logic              o_wr_last,
   output logic              o_wr_valid,
   input  logic              i_wr_ready,
   output logic              o_frame_done,
   output logic              o_ovf,
   output logic [1:0]        o_dbg_state
);

   // Write interface: a word transfers on any edge where o_wr_valid and
   // i_wr_ready are both high; o_wr_data/o_wr_last are stable while valid
   // is held, and ready with valid low has no effect.

   localparam int XW = $clog2(H_ACTIVE + 1);
   localparam int YW = $clog2(V_ACTIVE + 1);
   localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

   state_e             state_q, state_d;
   logic [PACK_CW-1:0] cnt_q, cnt_d, cnt_b;
   logic [XW-1:0]      x_q, x_d, x_b;
   logic [YW-1:0]      y_q, y_d, y_b;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;

   logic               pix_en;
   logic               last_pix;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [WORD_W:0]    head;

   // FSM: state register
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state; a frame start restarts from any state
   always_comb begin
      state_d = state_q;
      if (pix_en && last_pix) begin
         state_d = ST_DONE;
      end else if (i_vs) begin
         state_d = ST_ACTIVE;
      end
   end

   // FSM: outputs; a pixel coinciding with i_vs belongs to the new frame
   always_comb begin
      pix_en      = pi_flag && (i_vs || (state_q == ST_ACTIVE));
      o_dbg_state = state_q;
   end

   // Frame start clears position first, so a same-cycle pixel lands at slot 0.
   always_comb begin
      cnt_b    = i_vs ? '0 : cnt_q;
      x_b      = i_vs ? '0 : x_q;
      y_b      = i_vs ? '0 : y_q;
      last_pix = (x_b == X_LAST) && (y_b == Y_LAST);

      cnt_d = cnt_b;
      x_d   = x_b;
      y_d   = y_b;
      acc_d = acc_q;
      push  = 1'b0;
      if (pix_en) begin
         for (int i = 0; i < PIX_PER_WORD - 1; i++) begin
            if (cnt_b == PACK_CW'(i)) begin
               acc_d[i*PIX_W +: PIX_W] = pi_data;
            end
         end
         push  = (cnt_b == PACK_CW'(PIX_PER_WORD - 1));
         cnt_d = cnt_b + PACK_CW'(1);
         if (x_b == X_LAST) begin
            x_d = '0;
            y_d = (y_b == Y_LAST) ? '0 : y_b + YW'(1);
         end else begin
            x_d = x_b + XW'(1);
         end
      end
   end

   assign pop    = !fifo_empty && i_wr_ready;
   assign ovf_d  = (i_vs ? 1'b0 : ovf_q) | (push && fifo_full && !pop);
   assign done_d = pop && head[WORD_W];

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         x_q    <= '0;
         y_q    <= '0;
         acc_q  <= '0;
         ovf_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         x_q    <= x_d;
         y_q    <= y_d;
         acc_q  <= acc_d;
         ovf_q  <= ovf_d;
         done_q <= done_d;
      end
   end

   pix_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (WORD_W + 1)
   ) u_fifo (
      .clk         (sclk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i ({last_pix, pi_data, acc_q}),
      .pop_i       (i_wr_ready),
      .head_data_o (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign o_wr_data    = head[WORD_W-1:0];
   assign o_wr_last    = head[WORD_W];
   assign o_wr_valid   = !fifo_empty;
   assign o_frame_done = done_q;
   assign o_ovf        = ovf_q;

endmodule
